// File: rtl/fixed_point_divider_if.sv
// Operand/result handshake bundle for the fixed-point divider.
interface fixed_point_divider_if #(
  parameter int DW = 10,
  parameter int VW = 3,
  parameter int FW = 10
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_dividend;
  logic [VW-1:0]        in_divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW+FW-1:0]     out_quotient;
  logic [VW-1:0]        out_remainder;
  logic                 out_div_zero;

  modport master (
    output in_valid, in_dividend, in_divisor, out_ready,
    input  in_ready, out_valid, out_quotient, out_remainder, out_div_zero
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor, out_ready,
    output in_ready, out_valid, out_quotient, out_remainder, out_div_zero
  );
endinterface

// File: rtl/fixed_point_divider.sv
// Unsigned fixed-point restoring divider: quotient = floor(dividend*2^FW / divisor),
// one quotient bit per cycle, valid/ready on both sides.
module fixed_point_divider #(
  parameter int DW = 10,
  parameter int VW = 3,
  parameter int FW = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fixed_point_divider_if.slave  bus
);
  localparam int QW = DW + FW;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [QW-1:0]   num_q, num_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [VW:0]     rem_q, rem_d;
  logic [VW-1:0]   dvs_q, dvs_d;
  logic            dz_q, dz_d;

  logic [QW-1:0]   oq_q, oq_d;
  logic [VW-1:0]   or_q, or_d;
  logic            odz_q, odz_d;

  logic [VW+1:0]   step;

  // One restoring step: returns {quotient bit, new partial remainder}.
  function automatic logic [VW+1:0] div_step(input logic [VW:0] r,
                                             input logic nbit,
                                             input logic [VW-1:0] d);
    logic [VW:0] rs;
    logic [VW:0] dd;
    rs = {r[VW-1:0], nbit};
    dd = {1'b0, d};
    if (rs >= dd) return {1'b1, rs - dd};
    return {1'b0, rs};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    num_d       = num_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    dz_d        = dz_q;
    oq_d        = oq_q;
    or_d        = or_q;
    odz_d       = odz_q;
    step        = div_step(rem_q, num_q[QW-1], dvs_q);

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          num_d   = QW'(bus.in_dividend) << FW;
          dvs_d   = bus.in_divisor;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(QW);
          dz_d    = (bus.in_divisor == '0);
          state_d = (bus.in_divisor == '0) ? ZERO : CALC;
        end
      end
      CALC: begin
        rem_d = step[VW:0];
        quo_d = QW'({quo_q, step[VW+1]});
        num_d = num_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      ZERO: begin
        quo_d   = '1;
        rem_d   = '0;
        state_d = DONE;
      end
      DONE: begin
        // First DONE cycle publishes the result; afterwards wait for the consumer.
        if (!out_valid_q) begin
          oq_d        = quo_q;
          or_d        = rem_q[VW-1:0];
          odz_d       = dz_q;
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      oq_q        <= '0;
      or_q        <= '0;
      odz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      oq_q        <= oq_d;
      or_q        <= or_d;
      odz_q       <= odz_d;
    end
  end

  // Working datapath registers are don't-care until an operand is accepted.
  always_ff @(posedge clk) begin
    num_q <= num_d;
    quo_q <= quo_d;
    rem_q <= rem_d;
    dvs_q <= dvs_d;
    dz_q  <= dz_d;
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_quotient  = oq_q;
  assign bus.out_remainder = or_q;
  assign bus.out_div_zero  = odz_q;
endmodule
